// File: rtl/ripple_count_monitor.sv
// Clean-count monitor for an asynchronous ripple down-counter: synchronizes Q_IN,
// rejects one-cycle transient codes, and reports steps, underflows and illegal jumps.
module ripple_count_monitor #(
   parameter int CNT_W       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int EPOCH_W     = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [CNT_W-1:0]   Q_IN,
   input  logic               EN,
   input  logic               CLR,
   output logic [CNT_W-1:0]   Q_STABLE,
   output logic               VALID,
   output logic               STEP,
   output logic               UNDERFLOW,
   output logic [EPOCH_W-1:0] EPOCH,
   output logic               ERR
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] TRACK   = 2'd2;

   // Samples needed after reset before s and s_d both hold real Q_IN values.
   localparam int FILL   = SYNC_STAGES + 1;
   localparam int FILL_W = $clog2(FILL + 1);

   logic [CNT_W-1:0]  sync_p [SYNC_STAGES];
   logic [CNT_W-1:0]  s;
   logic [CNT_W-1:0]  s_d;
   logic [FILL_W-1:0] fill;
   logic [1:0]        state;
   logic              primed;
   logic              stable;

   function automatic logic [CNT_W-1:0] dec_wrap(input logic [CNT_W-1:0] v);
      return v - CNT_W'(1);
   endfunction

   assign s      = sync_p[SYNC_STAGES-1];
   assign primed = (fill == FILL_W'(FILL));
   assign stable = primed && (s == s_d);

   // Synchronizer and one-cycle history
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
         s_d  <= '0;
         fill <= '0;
      end else begin
         sync_p[0] <= Q_IN;
         for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
         s_d <= s;
         if (!primed) fill <= fill + FILL_W'(1);
      end
   end

   // Acquire/track control with registered pulses
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         Q_STABLE  <= '0;
         VALID     <= 1'b0;
         STEP      <= 1'b0;
         UNDERFLOW <= 1'b0;
         EPOCH     <= '0;
         ERR       <= 1'b0;
      end else begin
         STEP      <= 1'b0;
         UNDERFLOW <= 1'b0;
         if (CLR) begin
            EPOCH <= '0;
            ERR   <= 1'b0;
            VALID <= 1'b0;
            state <= IDLE;
         end else if (!EN) begin
            VALID <= 1'b0;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: state <= ACQUIRE;
               ACQUIRE: begin
                  if (stable) begin
                     Q_STABLE <= s;
                     VALID    <= 1'b1;
                     state    <= TRACK;
                  end
               end
               TRACK: begin
                  if (stable && (s != Q_STABLE)) begin
                     Q_STABLE <= s;
                     if (s == dec_wrap(Q_STABLE)) begin
                        STEP <= 1'b1;
                        if (Q_STABLE == '0) begin
                           UNDERFLOW <= 1'b1;
                           EPOCH     <= EPOCH + EPOCH_W'(1);
                        end
                     end else begin
                        ERR <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous ripple down-counter output Q.
- Brings the raw, ripple-glitchy count into the CLK domain and rejects transient codes.
- Tracks legal decrements and counts underflows (0 -> max wrap) in an extended epoch register.
- Flags illegal jumps so the system sees a clean count, a per-step pulse and a wrap count.

Parameters:
- CNT_W, 3, width of the monitored ripple count.
- SYNC_STAGES, 2, synchronizer flop depth on Q_IN (minimum 2).
- EPOCH_W, 8, width of the underflow (epoch) counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset (0 = reset).
- Q_IN  input  CNT_W  raw ripple down-counter value, asynchronous to CLK.
- EN  input  1  monitor enable; 0 forces IDLE.
- CLR  input  1  synchronous clear of EPOCH, ERR and FSM.
- Q_STABLE  output  CNT_W  last accepted filtered count.
- VALID  output  1  Q_STABLE holds a value accepted since the last (re)acquire.
- STEP  output  1  one-cycle pulse on each accepted legal decrement.
- UNDERFLOW  output  1  one-cycle pulse on an accepted 0 -> 2^CNT_W-1 decrement.
- EPOCH  output  EPOCH_W  underflow count; wraps modulo 2^EPOCH_W.
- ERR  output  1  sticky; set on any accepted non-decrement change.

Behaviour:
- Reset (RST=0, async): synchronizer, s_d, Q_STABLE, EPOCH = 0; VALID, STEP, UNDERFLOW, ERR = 0; FSM = IDLE. Reset mid-operation aborts everything immediately, with no pending pulse after release.
- Synchronizer: Q_IN passes through SYNC_STAGES flops; its output is s. Register s_d <= s every cycle, including while EN=0.
- Stability filter: stable = (s == s_d). A code seen on s for only one cycle is never accepted.
- Accept: stable && s != Q_STABLE in TRACK, or stable in ACQUIRE.
- Latency (SYNC_STAGES=2): Q_IN settled before edge 1 gives Q_STABLE/STEP updated after edge 4, i.e. SYNC_STAGES+2 edges.
- FSM states:
  - IDLE: VALID=0; outputs hold. Moves to ACQUIRE when EN=1 and CLR=0.
  - ACQUIRE: on first stable, Q_STABLE <= s, VALID <= 1, no STEP/ERR, then TRACK.
  - TRACK: on accept, with old o and new n:
    - n == (o-1) mod 2^CNT_W: STEP=1.
    - Additionally, if o == 0: UNDERFLOW=1 and EPOCH <= EPOCH+1.
    - Any other n: ERR <= 1, no STEP.
    - In all cases Q_STABLE <= n.
  - EN=0 in any state: next state IDLE. No pulses are issued that cycle, and Q_STABLE, EPOCH and ERR hold.
- CLR=1: EPOCH <= 0, ERR <= 0, FSM <= IDLE, VALID <= 0, pulses suppressed. CLR wins over a same-cycle accept or error. After CLR, reacquisition takes one stable sample with no STEP.
- STEP and UNDERFLOW are registered, exactly one cycle wide. They never assert in IDLE or ACQUIRE.
- EPOCH at 2^EPOCH_W-1 plus one underflow wraps to 0; no other flag is raised.
- Q_IN held constant: no accepts, so no pulses.

Test Plan:
- Reset mid-count: Q_IN=5 tracked with EPOCH=3, pull RST low mid-cycle -> all outputs 0 immediately, VALID=0. After release with Q_IN=5 -> VALID=1 at edge 4, no STEP.
- Clean descent: Q_IN 7,6,...,0,7, each held 4 cycles, EN=1 -> 8 STEP pulses, exactly one UNDERFLOW (at 0 -> 7), EPOCH=1, ERR=0, Q_STABLE ends 7.
- Ripple glitch: Q_IN 5, then 7 for exactly one CLK cycle, then 4 held -> Q_STABLE never 7, one STEP on 5 -> 4, ERR=0.
- Illegal jump: Q_IN 6 held, then 2 held -> ERR=1 (sticky), no STEP, Q_STABLE=2. Then 1 held -> STEP=1, ERR still 1. Then CLR -> ERR=0, EPOCH=0, VALID=0 for at least one cycle.
- Enable gap: tracking Q_IN=3, EN=0, Q_IN changes to 1, EN=1 -> reacquire Q_STABLE=1 with no STEP and no ERR.
- Epoch wrap (EPOCH_W=2): four 0 -> 7 underflows -> EPOCH 1,2,3,0, four UNDERFLOW pulses, ERR=0.
